wb_host_master: RTL and testbench

- Wishbone classic single-transfer initiator: the host side of the wbs_* slave port on wrapper_fibonacci.
- Accepts one read or write command at a time on a valid/ready command port and runs one classic cycle (cyc/stb held until ack).
- Returns read data, or a timeout error, on a valid/ready response port.
- Used as the synthesizable bus driver in the wrapper bench and as an on-chip sequencer front end.

---
 rtl/wb_host_master.sv | 129 ++++++++++++
 tb/tb_wb_host_master.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wb_host_master.sv
// Wishbone classic single-transfer initiator: one command in, one cyc/stb cycle
// on the bus, one response (read data or timeout error) out.
module wb_host_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_we,
  input  logic [ADDR_W-1:0]   cmd_adr,
  input  logic [DATA_W-1:0]   cmd_dat,
  input  logic [DATA_W/8-1:0] cmd_sel,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_dat,
  output logic                rsp_err,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  input  logic                wbm_ack_i,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  output logic                busy
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              cyc_d, we_d, rsp_valid_d, rsp_err_d;
  logic [SEL_W-1:0]  sel_d;
  logic [ADDR_W-1:0] adr_d;
  logic [DATA_W-1:0] dat_d, rsp_dat_d;

  // Ready depends only on state (and reset), never on cmd_valid.
  assign cmd_ready = (state == ST_IDLE) & ~wb_rst_i;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    cyc_d       = wbm_cyc_o;
    we_d        = wbm_we_o;
    sel_d       = wbm_sel_o;
    adr_d       = wbm_adr_o;
    dat_d       = wbm_dat_o;
    rsp_valid_d = rsp_valid;
    rsp_dat_d   = rsp_dat;
    rsp_err_d   = rsp_err;
    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cyc_d   = 1'b1;
          we_d    = cmd_we;
          sel_d   = cmd_sel;
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          cnt_d   = '0;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (wbm_ack_i || (cnt == CNT_W'(TIMEOUT - 1))) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = '0;
          adr_d       = '0;
          dat_d       = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ~wbm_ack_i;
          rsp_dat_d   = (wbm_ack_i && !wbm_we_o) ? wbm_dat_i : '0;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      wbm_cyc_o <= cyc_d;
      wbm_stb_o <= cyc_d;
      wbm_we_o  <= we_d;
      wbm_sel_o <= sel_d;
      wbm_adr_o <= adr_d;
      wbm_dat_o <= dat_d;
      rsp_valid <= rsp_valid_d;
      rsp_dat   <= rsp_dat_d;
      rsp_err   <= rsp_err_d;
      busy      <= (state_d != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_wb_host_master.sv
// Bench for wb_host_master: directed scenarios with literal expectations, then
// random commands/slave latencies checked every cycle against a transaction model.
module tb_wb_host_master;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_ready = 1'b0, ack = 1'b0;
  logic [31:0] dat_i = '0;
  logic        cmd_ready, rsp_valid, rsp_err, cyc, stb, we, busy;
  logic [31:0] rsp_dat, adr, dat_o;
  logic [3:0]  sel;

  int n_pass = 0;
  int n_total = 0;

  // Transaction-level model: which phase the transfer is in and its contents.
  bit          m_in_bus = 0, m_in_rsp = 0;
  int          m_age = 0;   // stb cycles already elapsed without ack
  int          m_lat = 0;   // stb cycle index at which the slave will ack
  bit          m_we = 0;
  logic [31:0] m_adr = '0, m_dat = '0, m_rsp_dat = '0;
  logic [3:0]  m_sel = '0;
  bit          m_rsp_err = 0;

  wb_host_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_ack_i(ack), .wbm_dat_i(dat_i),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    if (rst) begin
      m_in_bus = 0; m_in_rsp = 0; m_age = 0;
    end else if (m_in_bus) begin
      if (ack) begin
        m_rsp_dat = m_we ? 32'h0 : dat_i; m_rsp_err = 0;
        m_in_bus = 0; m_in_rsp = 1;
      end else if (m_age + 1 == int'(TO)) begin
        m_rsp_dat = 32'h0; m_rsp_err = 1;
        m_in_bus = 0; m_in_rsp = 1;
      end else begin
        m_age++;
      end
    end else if (m_in_rsp) begin
      if (rsp_ready) m_in_rsp = 0;
    end else if (cmd_valid) begin
      m_we = cmd_we; m_adr = cmd_adr; m_dat = cmd_dat; m_sel = cmd_sel;
      m_in_bus = 1; m_age = 0;
      m_lat = $urandom_range(0, TO + 1);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare();
    chk("cmd_ready", 32'(cmd_ready), 32'(!m_in_bus && !m_in_rsp && !rst));
    chk("busy", 32'(busy), 32'(m_in_bus || m_in_rsp));
    chk("cyc", 32'(cyc), 32'(m_in_bus));
    chk("stb", 32'(stb), 32'(m_in_bus));
    chk("we", 32'(we), m_in_bus ? 32'(m_we) : 32'h0);
    chk("adr", adr, m_in_bus ? m_adr : 32'h0);
    chk("dat_o", dat_o, m_in_bus ? m_dat : 32'h0);
    chk("sel", 32'(sel), m_in_bus ? 32'(m_sel) : 32'h0);
    chk("rsp_valid", 32'(rsp_valid), 32'(m_in_rsp));
    if (m_in_rsp) begin
      chk("rsp_dat", rsp_dat, m_rsp_dat);
      chk("rsp_err", 32'(rsp_err), 32'(m_rsp_err));
    end
  endtask

  // One clock: model consumes the driven inputs, DUT outputs checked at the next negedge.
  task automatic tick();
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1; cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_sel = 4'hF;
    tick();
    cmd_valid = 0;
  endtask

  initial begin
    // Reset held two cycles while a misbehaving slave acks.
    rst = 1; ack = 1; cmd_valid = 1;
    tick(); tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    chk("rst_cyc", 32'(cyc), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    rst = 0; ack = 0; cmd_valid = 0;
    tick();
    chk("rel_cmd_ready", 32'(cmd_ready), 32'h1);

    // Zero-wait write.
    issue(1, 32'h3000_0000, 32'h0000_0005);
    chk("wr_cyc", 32'(cyc), 32'h1);
    chk("wr_adr", adr, 32'h3000_0000);
    chk("wr_dat", dat_o, 32'h0000_0005);
    chk("wr_sel", 32'(sel), 32'hF);
    ack = 1; dat_i = 32'hdead_beef;
    tick();
    ack = 0;
    chk("wr_cyc_drop", 32'(cyc), 32'h0);
    chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("wr_rsp_dat", rsp_dat, 32'h0);
    chk("wr_rsp_err", 32'(rsp_err), 32'h0);
    rsp_ready = 1; tick(); rsp_ready = 0;
    chk("wr_back_idle", 32'(cmd_ready), 32'h1);

    // Read with 3 wait states (ack on the last legal cycle) and a stalled consumer.
    issue(0, 32'h3000_0004, 32'h0);
    repeat (3) tick();
    chk("rd_still_bus", 32'(cyc), 32'h1);
    ack = 1; dat_i = 32'h0000_0037;
    tick();
    ack = 0; dat_i = 32'h1234_5678;
    chk("rd_rsp_dat", rsp_dat, 32'h0000_0037);
    chk("rd_rsp_err", 32'(rsp_err), 32'h0);
    cmd_valid = 1;
    repeat (5) tick();
    chk("rd_hold_dat", rsp_dat, 32'h0000_0037);
    chk("rd_hold_ready", 32'(cmd_ready), 32'h0);
    cmd_valid = 0; rsp_ready = 1; tick(); rsp_ready = 0;

    // Timeout on an unmapped address, then a late ack.
    issue(0, 32'h4000_0000, 32'h0);
    repeat (3) tick();
    chk("to_cyc_3", 32'(cyc), 32'h1);
    tick();
    chk("to_cyc_drop", 32'(cyc), 32'h0);
    chk("to_rsp_err", 32'(rsp_err), 32'h1);
    chk("to_rsp_dat", rsp_dat, 32'h0);
    ack = 1; tick(); ack = 0;
    chk("to_late_ack", 32'(rsp_err), 32'h1);
    rsp_ready = 1; tick(); rsp_ready = 0;
    ack = 1; tick(); ack = 0;
    chk("idle_ack_busy", 32'(busy), 32'h0);
    chk("idle_ack_rsp", 32'(rsp_valid), 32'h0);

    // Reset in the second bus cycle, then a normal read.
    issue(0, 32'h3000_0008, 32'h0);
    tick();
    rst = 1; tick(); rst = 0;
    chk("mid_rst_cyc", 32'(cyc), 32'h0);
    chk("mid_rst_rsp", 32'(rsp_valid), 32'h0);
    tick();
    issue(0, 32'h3000_0004, 32'h0);
    ack = 1; dat_i = 32'h0000_0037; tick(); ack = 0;
    chk("post_rst_rsp", rsp_dat, 32'h0000_0037);
    rsp_ready = 1; tick(); rsp_ready = 0;

    // Random traffic with random slave latency (including timeouts) and rare resets.
    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      cmd_valid = ($urandom_range(0, 9) < 7);
      cmd_we    = 1'($urandom);
      cmd_adr   = $urandom;
      cmd_dat   = $urandom;
      cmd_sel   = 4'($urandom);
      rsp_ready = 1'($urandom);
      dat_i     = $urandom;
      ack       = m_in_bus ? (m_age == m_lat) : ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
